// File: rtl/pkg_alu.sv
// Shared types for the sequential ALU: opcodes, FSM states and shift-amount sizing.
package pkg_alu;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_NEG = 4'd2,
        OP_MUL = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_NOT = 4'd6,
        OP_XOR = 4'd7,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_SAR = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DONE
    } alu_state_e;

    // One extra bit so amounts >= the result width are representable.
    function automatic int unsigned shamt_width(input int unsigned dw_out);
        return $clog2(dw_out) + 1;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Shift-add multiplier on operand magnitudes; done is asserted during the last of DW_IN steps.
module seq_mult #(
    parameter int unsigned DW_IN = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DW_IN-1:0]     a,
    input  logic [DW_IN-1:0]     b,
    output logic                 done,
    output logic [2*DW_IN-1:0]   product
);

    localparam int unsigned PW = 2 * DW_IN;
    localparam int unsigned CW = $clog2(DW_IN + 1);

    logic              busy;
    logic              neg;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [DW_IN-1:0]  mplier;
    logic [PW-1:0]     acc_next;
    logic [DW_IN-1:0]  mag_a;
    logic [DW_IN-1:0]  mag_b;

    always_comb begin
        mag_a    = a[DW_IN-1] ? (~a + DW_IN'(1)) : a;
        mag_b    = b[DW_IN-1] ? (~b + DW_IN'(1)) : b;
        acc_next = mplier[0] ? (acc + mcand) : acc;
        done     = busy && (cnt == CW'(DW_IN - 1));
        // Final step's partial sum is signed here so the result is ready on the same edge.
        product  = neg ? (~acc_next + PW'(1)) : acc_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            neg    <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            neg    <= a[DW_IN-1] ^ b[DW_IN-1];
            cnt    <= '0;
            acc    <= '0;
            mcand  <= PW'(mag_a);
            mplier <= mag_b;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle combinational ops, multi-cycle multiply, registered result and flags.
module seq_alu
    import pkg_alu::*;
#(
    parameter int unsigned DW_IN  = 5,
    parameter int unsigned DW_OUT = 8,
    parameter int unsigned NO     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DW_IN-1:0]  i_numberA,
    input  logic [DW_IN-1:0]  i_numberB,
    input  logic [NO-1:0]     i_control,
    output logic              o_busy,
    output logic              o_ready,
    output logic [DW_OUT-1:0] o_result,
    output logic              o_zero,
    output logic              o_negative,
    output logic              o_overflow,
    output logic              o_carry,
    output logic              o_error
);

    localparam int unsigned SW = shamt_width(DW_OUT);
    localparam int unsigned PW = (2 * DW_IN > DW_OUT) ? 2 * DW_IN : DW_OUT;

    alu_state_e state, state_next;

    logic                 accept, is_mul, mul_done;
    logic [2*DW_IN-1:0]   mul_product;
    logic [PW-1:0]        p_ext;
    logic [DW_OUT-1:0]    mul_res;
    logic                 mul_v;
    logic [DW_OUT-1:0]    a_ext, b_ext, alu_res;
    logic [DW_OUT:0]      sum, diff;
    logic [SW-1:0]        amt;
    logic                 big, alu_v, alu_c, alu_e;

    always_comb begin
        state_next = state;
        o_busy     = (state != S_IDLE);
        o_ready    = (state == S_DONE);
        case (state)
            S_IDLE:  if (i_start) state_next = is_mul ? S_MULT : S_DONE;
            S_MULT:  if (mul_done) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign is_mul = (i_control == NO'(OP_MUL));
    assign accept = (state == S_IDLE) && i_start;

    seq_mult #(
        .DW_IN (DW_IN)
    ) u_mult (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (accept && is_mul),
        .a       (i_numberA),
        .b       (i_numberB),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        p_ext   = PW'($signed(mul_product));
        mul_res = p_ext[DW_OUT-1:0];
        mul_v   = (PW'($signed(mul_res)) != p_ext);
    end

    always_comb begin
        a_ext   = DW_OUT'($signed(i_numberA));
        b_ext   = DW_OUT'($signed(i_numberB));
        sum     = {1'b0, a_ext} + {1'b0, b_ext};
        diff    = {1'b0, a_ext} + {1'b0, ~b_ext} + (DW_OUT + 1)'(1);
        amt     = b_ext[SW-1:0];
        big     = (32'(amt) >= DW_OUT);
        alu_res = '0;
        alu_v   = 1'b0;
        alu_c   = 1'b0;
        alu_e   = 1'b0;
        case (i_control)
            NO'(OP_ADD): begin
                alu_res = sum[DW_OUT-1:0];
                alu_c   = sum[DW_OUT];
                alu_v   = (a_ext[DW_OUT-1] == b_ext[DW_OUT-1]) && (alu_res[DW_OUT-1] != a_ext[DW_OUT-1]);
            end
            NO'(OP_SUB): begin
                alu_res = diff[DW_OUT-1:0];
                alu_c   = ~diff[DW_OUT];
                alu_v   = (a_ext[DW_OUT-1] != b_ext[DW_OUT-1]) && (alu_res[DW_OUT-1] != a_ext[DW_OUT-1]);
            end
            NO'(OP_NEG): alu_res = ~b_ext + DW_OUT'(1);
            NO'(OP_MUL): alu_res = '0;
            NO'(OP_AND): alu_res = a_ext & b_ext;
            NO'(OP_OR):  alu_res = a_ext | b_ext;
            NO'(OP_NOT): alu_res = ~a_ext;
            NO'(OP_XOR): alu_res = a_ext ^ b_ext;
            NO'(OP_SHL): alu_res = big ? '0 : (a_ext << amt);
            NO'(OP_SHR): alu_res = big ? '0 : (a_ext >> amt);
            NO'(OP_SAR): alu_res = big ? {DW_OUT{a_ext[DW_OUT-1]}} : DW_OUT'($signed(a_ext) >>> amt);
            default:     alu_e   = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_result   <= '0;
            o_zero     <= 1'b0;
            o_negative <= 1'b0;
            o_overflow <= 1'b0;
            o_carry    <= 1'b0;
            o_error    <= 1'b0;
        end else if (accept && !is_mul) begin
            o_result   <= alu_res;
            o_zero     <= (alu_res == '0) && !alu_e;
            o_negative <= alu_res[DW_OUT-1];
            o_overflow <= alu_v;
            o_carry    <= alu_c;
            o_error    <= alu_e;
        end else if ((state == S_MULT) && mul_done) begin
            o_result   <= mul_res;
            o_zero     <= (mul_res == '0);
            o_negative <= mul_res[DW_OUT-1];
            o_overflow <= mul_v;
            o_carry    <= 1'b0;
            o_error    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu with hand-computed expectations at DW_IN=5, DW_OUT=8.
module tb_seq_alu;

    localparam int unsigned DW_IN  = 5;
    localparam int unsigned DW_OUT = 8;
    localparam int unsigned NO     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [DW_IN-1:0]  num_a;
    logic [DW_IN-1:0]  num_b;
    logic [NO-1:0]     ctl;
    logic              busy, ready;
    logic [DW_OUT-1:0] result;
    logic              zero, negative, overflow, carry, error;

    int vectors     = 0;
    int miscompares = 0;
    int lat;
    int pulses;

    always #5 clk = ~clk;

    seq_alu #(
        .DW_IN  (DW_IN),
        .DW_OUT (DW_OUT),
        .NO     (NO)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_numberA  (num_a),
        .i_numberB  (num_b),
        .i_control  (ctl),
        .o_busy     (busy),
        .o_ready    (ready),
        .o_result   (result),
        .o_zero     (zero),
        .o_negative (negative),
        .o_overflow (overflow),
        .o_carry    (carry),
        .o_error    (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flags packed as {zero, negative, overflow, carry, error}.
    task automatic check_out(input string tag, input logic [7:0] res, input logic [4:0] flags);
        check({tag, ".result"}, 32'(result), 32'(res));
        check({tag, ".flags"}, 32'({zero, negative, overflow, carry, error}), 32'(flags));
    endtask

    // Returns #1 after the accept edge; operands are then scrambled to prove they were captured.
    task automatic launch(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        start = 1'b1;
        ctl   = op;
        num_a = a;
        num_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        ctl   = 4'd0;
        num_a = ~a;
        num_b = ~b;
    endtask

    task automatic wait_ready(output int l);
        l = 1;
        while (!ready && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
        if (!ready) l = 99;
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk);
        #1;
        check({tag, ".ready_drop"}, 32'(ready), 32'd0);
        check({tag, ".idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        num_a = '0;
        num_b = '0;
        ctl   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.ready", 32'(ready), 32'd0);
        check_out("reset", 8'h00, 5'b00000);
        rst_n = 1'b1;

        launch(4'd0, 5'h0F, 5'h0F);
        wait_ready(lat);
        check("add15.lat", 32'(lat), 32'd1);
        check_out("add15", 8'h1E, 5'b00000);
        finish_op("add15");

        launch(4'd1, 5'h10, 5'h0F);
        wait_ready(lat);
        check("sub.lat", 32'(lat), 32'd1);
        check_out("sub", 8'hE1, 5'b01000);
        finish_op("sub");

        launch(4'd3, 5'h07, 5'h1D);
        check("mul7.busy", 32'(busy), 32'd1);
        wait_ready(lat);
        check("mul7.lat", 32'(lat), 32'd6);
        check_out("mul7", 8'hEB, 5'b01000);
        finish_op("mul7");

        launch(4'd3, 5'h10, 5'h10);
        wait_ready(lat);
        check("mul16.lat", 32'(lat), 32'd6);
        check_out("mul16", 8'h00, 5'b10100);
        finish_op("mul16");

        launch(4'd10, 5'h18, 5'h02);
        wait_ready(lat);
        check_out("sar2", 8'hFE, 5'b01000);
        finish_op("sar2");

        launch(4'd8, 5'h01, 5'h09);
        wait_ready(lat);
        check_out("shl9", 8'h00, 5'b10000);
        finish_op("shl9");

        launch(4'd10, 5'h18, 5'h0C);
        wait_ready(lat);
        check_out("sar12", 8'hFF, 5'b01000);
        finish_op("sar12");

        launch(4'd9, 5'h18, 5'h03);
        wait_ready(lat);
        check_out("shr3", 8'h1F, 5'b00000);
        finish_op("shr3");

        launch(4'd2, 5'h00, 5'h05);
        wait_ready(lat);
        check_out("neg", 8'hFB, 5'b01000);
        finish_op("neg");

        launch(4'd7, 5'h05, 5'h1F);
        wait_ready(lat);
        check_out("xor", 8'hFA, 5'b01000);
        finish_op("xor");

        launch(4'd0, 5'h1F, 5'h01);
        wait_ready(lat);
        check_out("add_carry", 8'h00, 5'b10010);
        finish_op("add_carry");

        launch(4'd1, 5'h00, 5'h01);
        wait_ready(lat);
        check_out("sub_borrow", 8'hFF, 5'b01010);
        finish_op("sub_borrow");

        launch(4'd15, 5'h03, 5'h04);
        wait_ready(lat);
        check("inv.lat", 32'(lat), 32'd1);
        check("inv.result", 32'(result), 32'd0);
        check("inv.error", 32'(error), 32'd1);
        finish_op("inv");

        // Start pulse mid-multiply must be ignored and yield exactly one ready pulse.
        launch(4'd3, 5'h03, 5'h05);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) begin
                start = 1'b1;
                ctl   = 4'd0;
                num_a = 5'h01;
                num_b = 5'h01;
            end
            if (i == 2) start = 1'b0;
            if (ready) begin
                pulses++;
                check_out("mul_ignore", 8'h0F, 5'b00000);
            end
            @(posedge clk);
            #1;
        end
        check("mul_ignore.pulses", 32'(pulses), 32'd1);

        launch(4'd3, 5'h07, 5'h07);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        ctl   = 4'd0;
        @(posedge clk);
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.ready", 32'(ready), 32'd0);
        check_out("abort", 8'h00, 5'b00000);
        @(posedge clk);
        #1;
        check("rst_start.busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (ready) pulses++;
            @(posedge clk);
            #1;
        end
        check("abort.no_ready", 32'(pulses), 32'd0);
        check("abort.idle", 32'(busy), 32'd0);

        launch(4'd0, 5'h03, 5'h04);
        wait_ready(lat);
        check("post_rst.lat", 32'(lat), 32'd1);
        check_out("post_rst", 8'h07, 5'b00000);
        finish_op("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
